// File: rtl/isp_ae_response_gen_pkg.sv
// Shared response codes and FSM state encoding for the auto-exposure statistics engine.
package isp_ae_pkg;

  localparam logic [1:0] AE_RESP_HOLD = 2'b00;
  localparam logic [1:0] AE_RESP_UP   = 2'b01;
  localparam logic [1:0] AE_RESP_DOWN = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    CMP  = 2'd2
  } ae_state_t;

endpackage

// File: rtl/isp_ae_response_gen_if.sv
// Raw pixel bus into the AE engine plus its response/debug outputs.
// master = pixel source / response consumer, slave = AE engine.
interface isp_ae_response_gen_if #(
  parameter int BITS     = 12,
  parameter int CNT_BITS = 21,
  parameter int SUM_BITS = BITS + CNT_BITS
);
  logic                in_vsync;
  logic                in_href;
  logic [BITS-1:0]     in_raw;
  logic [1:0]          ae_response;
  logic                ae_response_valid;
  logic [SUM_BITS-1:0] ae_sum;
  logic [CNT_BITS-1:0] ae_count;

  modport master (
    output in_vsync, in_href, in_raw,
    input  ae_response, ae_response_valid, ae_sum, ae_count
  );

  modport slave (
    input  in_vsync, in_href, in_raw,
    output ae_response, ae_response_valid, ae_sum, ae_count
  );
endinterface

// File: rtl/isp_ae_response_gen_accum.sv
// Saturating luma sum / pixel count accumulator; clear wins over add, both take effect next edge.
// No backpressure: one pixel per cycle is always accepted.
module isp_ae_accum #(
  parameter int BITS     = 12,
  parameter int CNT_BITS = 21,
  parameter int SUM_BITS = BITS + CNT_BITS
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                add,
  input  logic [BITS-1:0]     din,
  output logic [SUM_BITS-1:0] sum,
  output logic [CNT_BITS-1:0] count
);

  logic [SUM_BITS:0] sum_ext;

  // One spare bit catches the carry so the sum can clamp instead of wrapping.
  assign sum_ext = {1'b0, sum} + {{(SUM_BITS + 1 - BITS){1'b0}}, din};

  always_ff @(posedge pclk) begin
    if (!rst_n || clr) begin
      sum   <= '0;
      count <= '0;
    end else if (add) begin
      sum <= sum_ext[SUM_BITS] ? '1 : sum_ext[SUM_BITS-1:0];
      if (count != '1) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/isp_ae_response_gen.sv
// Frame-mean auto-exposure engine: one gain step request per frame, strobe 2 cycles after vsync rise.
// No backpressure: the one-cycle strobe must be captured by the consumer when it appears.
module isp_ae_response_gen
  import isp_ae_pkg::*;
#(
  parameter int BITS     = 12,
  parameter int WIDTH    = 1920,
  parameter int HEIGHT   = 1080,
  parameter int CNT_BITS = $clog2(WIDTH * HEIGHT + 1),
  parameter int SUM_BITS = BITS + CNT_BITS
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [BITS-1:0] low_th,
  input  logic [BITS-1:0] high_th,
  isp_ae_response_gen_if.slave bus
);

  ae_state_t           state, state_nxt;
  logic                vsync_d;
  logic                vsync_rise;
  logic                latch;
  logic [SUM_BITS-1:0] acc_sum, sum_lat, lo_ref, hi_ref;
  logic [CNT_BITS-1:0] acc_cnt, cnt_lat;
  logic [SUM_BITS-1:0] cnt_ext, low_ext, high_ext;
  logic [1:0]          resp_q, resp_nxt;
  logic                vld_q, vld_nxt;

  assign vsync_rise = bus.in_vsync & ~vsync_d;

  isp_ae_accum #(.BITS(BITS), .CNT_BITS(CNT_BITS), .SUM_BITS(SUM_BITS)) u_accum (
    .pclk  (pclk),
    .rst_n (rst_n),
    .clr   (vsync_rise),
    .add   (bus.in_href & ~bus.in_vsync),
    .din   (bus.in_raw),
    .sum   (acc_sum),
    .count (acc_cnt)
  );

  // count*threshold fits exactly in SUM_BITS since SUM_BITS = CNT_BITS + BITS.
  assign cnt_ext  = {{BITS{1'b0}}, cnt_lat};
  assign low_ext  = {{CNT_BITS{1'b0}}, low_th};
  assign high_ext = {{CNT_BITS{1'b0}}, high_th};

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    resp_nxt  = AE_RESP_HOLD;
    vld_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (vsync_rise && enable) begin
          state_nxt = MULT;
          latch     = 1'b1;
        end
      end
      MULT: state_nxt = CMP;
      CMP: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b1;
        if (sum_lat < lo_ref)      resp_nxt = AE_RESP_UP;
        else if (sum_lat > hi_ref) resp_nxt = AE_RESP_DOWN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state   <= IDLE;
      vsync_d <= 1'b0;
      sum_lat <= '0;
      cnt_lat <= '0;
      lo_ref  <= '0;
      hi_ref  <= '0;
      resp_q  <= AE_RESP_HOLD;
      vld_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      vsync_d <= bus.in_vsync;
      resp_q  <= resp_nxt;
      vld_q   <= vld_nxt;
      if (latch) begin
        sum_lat <= acc_sum;
        cnt_lat <= acc_cnt;
      end
      if (state == MULT) begin
        lo_ref <= cnt_ext * low_ext;
        hi_ref <= cnt_ext * high_ext;
      end
    end
  end

  assign bus.ae_response       = resp_q;
  assign bus.ae_response_valid = vld_q;
  assign bus.ae_sum            = sum_lat;
  assign bus.ae_count          = cnt_lat;

endmodule

// File: tb/tb_isp_ae_response_gen.sv
// Directed bench for isp_ae_response_gen with a strobe scoreboard.
module tb_isp_ae_response_gen;
  import isp_ae_pkg::*;

  localparam int BITS     = 12;
  localparam int WIDTH    = 4;
  localparam int HEIGHT   = 4;
  localparam int CNT_BITS = $clog2(WIDTH * HEIGHT + 1);
  localparam int SUM_BITS = BITS + CNT_BITS;

  logic            pclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b1;
  logic [BITS-1:0] low_th = 12'd1000;
  logic [BITS-1:0] high_th = 12'd3000;

  always #5 pclk = ~pclk;

  isp_ae_response_gen_if #(.BITS(BITS), .CNT_BITS(CNT_BITS), .SUM_BITS(SUM_BITS)) bus ();

  isp_ae_response_gen #(
    .BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CNT_BITS(CNT_BITS), .SUM_BITS(SUM_BITS)
  ) dut (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .enable  (enable),
    .low_th  (low_th),
    .high_th (high_th),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] resp;
    int         sum;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   m_sum = 0;
  int   m_cnt = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_resp(input int s, input int c);
    if (s < c * int'(low_th))       return AE_RESP_UP;
    else if (s > c * int'(high_th)) return AE_RESP_DOWN;
    else                            return AE_RESP_HOLD;
  endfunction

  always @(negedge pclk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (bus.ae_response_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {31'd0, bus.ae_response_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_resp", {30'd0, bus.ae_response}, {30'd0, e.resp});
          check("strobe_sum", {{(32-SUM_BITS){1'b0}}, bus.ae_sum}, e.sum);
          check("strobe_cnt", {{(32-CNT_BITS){1'b0}}, bus.ae_count}, e.cnt);
          check("strobe_cycle", cyc, e.cyc);
        end
      end else begin
        check("resp_idle", {30'd0, bus.ae_response}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic pixels(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      bus.in_href = 1'b1;
      bus.in_raw  = BITS'(v);
      m_sum += v;
      m_cnt++;
      step();
    end
    bus.in_href = 1'b0;
  endtask

  // Rise is sampled at the next edge N; the strobe is seen at the negedge after edge N+2.
  task automatic push_expected();
    exp_t e;
    e.resp = model_resp(m_sum, m_cnt);
    e.sum  = m_sum;
    e.cnt  = m_cnt;
    e.cyc  = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic frame_end();
    if (enable) push_expected();
    m_sum = 0;
    m_cnt = 0;
    bus.in_vsync = 1'b1;
    step();
    bus.in_vsync = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    bus.in_vsync = 1'b0;
    bus.in_href  = 1'b0;
    bus.in_raw   = '0;
    repeat (3) step();
    check("rst_sum", {{(32-SUM_BITS){1'b0}}, bus.ae_sum}, 32'd0);
    check("rst_cnt", {{(32-CNT_BITS){1'b0}}, bus.ae_count}, 32'd0);
    check("rst_vld", {31'd0, bus.ae_response_valid}, 32'd0);
    check("rst_resp", {30'd0, bus.ae_response}, 32'd0);
    rst_n = 1'b1;

    pixels(16, 500);
    frame_end();
    check("f1_sum", {{(32-SUM_BITS){1'b0}}, bus.ae_sum}, 32'd8000);
    check("f1_cnt", {{(32-CNT_BITS){1'b0}}, bus.ae_count}, 32'd16);

    pixels(16, 4000);
    frame_end();
    check("f2_sum", {{(32-SUM_BITS){1'b0}}, bus.ae_sum}, 32'd64000);

    pixels(16, 2000);
    frame_end();
    pixels(16, 1000);
    frame_end();
    check("f4_sum_eq_lo", {{(32-SUM_BITS){1'b0}}, bus.ae_sum}, 32'd16000);

    // Empty frame whose blanking carries href pulses; those must not reach the next frame.
    push_expected();
    bus.in_vsync = 1'b1;
    bus.in_href  = 1'b1;
    bus.in_raw   = 12'd999;
    repeat (3) step();
    bus.in_href  = 1'b0;
    bus.in_vsync = 1'b0;
    repeat (5) step();
    frame_end();
    check("empty_cnt", {{(32-CNT_BITS){1'b0}}, bus.ae_count}, 32'd0);

    pixels(8, 4000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_sum = 0;
    m_cnt = 0;
    pixels(8, 500);
    push_expected();
    m_sum = 0;
    m_cnt = 0;
    bus.in_vsync = 1'b1;
    step();
    bus.in_vsync = 1'b0;
    step();
    bus.in_vsync = 1'b1;
    step();
    bus.in_vsync = 1'b0;
    repeat (6) step();
    check("rst_frame_sum", {{(32-SUM_BITS){1'b0}}, bus.ae_sum}, 32'd4000);
    check("rst_frame_cnt", {{(32-CNT_BITS){1'b0}}, bus.ae_count}, 32'd8);

    enable = 1'b0;
    pixels(16, 4000);
    frame_end();
    check("dis_sum_held", {{(32-SUM_BITS){1'b0}}, bus.ae_sum}, 32'd4000);
    check("dis_cnt_held", {{(32-CNT_BITS){1'b0}}, bus.ae_count}, 32'd8);
    enable = 1'b1;
    pixels(16, 500);
    frame_end();
    check("reen_sum", {{(32-SUM_BITS){1'b0}}, bus.ae_sum}, 32'd8000);

    repeat (5) step();
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
